// File: rtl/fact_pkg.sv
// -----------------------------------------------------------------------------
// fact_pkg
// Shared definitions for the factorial accelerator MMIO slice: operand and
// result widths, the register-map word offsets, the largest operand whose
// factorial fits in 32 bits, and the multiply state machine encoding.
// Optional feature macro used by the slice: FACT_ERR_EN (overflow detection).
// -----------------------------------------------------------------------------
package fact_pkg;

    // Operand width (also the down-counter width) and result/product width.
    localparam int FACT_N_WIDTH   = 4;
    localparam int FACT_RES_WIDTH = 32;

    // Largest n whose factorial still fits in FACT_RES_WIDTH bits.
    localparam int FACT_MAX_N = 12;

    // Word offsets within the factorial slot (processor address bits [3:2]).
    localparam logic [1:0] FACT_OFS_N      = 2'd0;
    localparam logic [1:0] FACT_OFS_GO     = 2'd1;
    localparam logic [1:0] FACT_OFS_STATUS = 2'd2;
    localparam logic [1:0] FACT_OFS_RESULT = 2'd3;

    // Iterative multiply state machine encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DONE = 2'd2
    } fact_state_e;

endpackage

// File: rtl/fact_mmio_if.sv
// -----------------------------------------------------------------------------
// fact_mmio_if
// Decoder-side bus for the factorial slot.
//   we  : write strobe for this slot
//   a   : word offset (processor address bits [3:2])
//   wd  : write data
//   rd  : read data back to the processor read-data mux (combinational)
// Modports: master = decoder/processor side, slave = fact_mmio.
// -----------------------------------------------------------------------------
interface fact_mmio_if;

    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    modport master (
        output we,
        output a,
        output wd,
        input  rd
    );

    modport slave (
        input  we,
        input  a,
        input  wd,
        output rd
    );

endinterface

// File: rtl/fact_fsm.sv
// -----------------------------------------------------------------------------
// fact_fsm
// Iterative factorial engine: one 32x4 multiply per cycle on a down-counter.
// A start pulse loads prod=1 and cnt=n; the engine multiplies prod by cnt and
// decrements until cnt<=1, then latches prod into result and raises done.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : GO accepted this cycle (ignored while busy)
//   n          : operand sampled when start is accepted
//   busy       : high while multiplying
//   done       : computation finished (cleared by the next accepted start)
//   err        : overflow flag (only with FACT_ERR_EN, otherwise tied to 0)
//   result     : last completed result, held until the next completion
// Macro: FACT_ERR_EN enables overflow detection for n > FACT_MAX_N.
// -----------------------------------------------------------------------------
module fact_fsm
    import fact_pkg::*;
#(
    parameter int N_WIDTH   = FACT_N_WIDTH,
    parameter int RES_WIDTH = FACT_RES_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N_WIDTH-1:0]   n,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [RES_WIDTH-1:0] result
);

    fact_state_e          state, state_nxt;
    logic [RES_WIDTH-1:0] prod, prod_nxt;
    logic [N_WIDTH-1:0]   cnt, cnt_nxt;
    logic [RES_WIDTH-1:0] result_q, result_nxt;
    logic                 done_q, done_nxt;

`ifdef FACT_ERR_EN
    logic                 err_q, err_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            prod     <= '0;
            cnt      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef FACT_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            prod     <= prod_nxt;
            cnt      <= cnt_nxt;
            result_q <= result_nxt;
            done_q   <= done_nxt;
`ifdef FACT_ERR_EN
            err_q    <= err_nxt;
`endif
        end
    end

    // The overflow check happens on the first MULT cycle, when cnt still holds
    // the original operand; later cycles only see smaller counts, so it can
    // never fire mid-computation.
    always_comb begin
        state_nxt  = state;
        prod_nxt   = prod;
        cnt_nxt    = cnt;
        result_nxt = result_q;
        done_nxt   = done_q;
`ifdef FACT_ERR_EN
        err_nxt    = err_q;
`endif
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    done_nxt  = 1'b0;
`ifdef FACT_ERR_EN
                    err_nxt   = 1'b0;
`endif
                    prod_nxt  = RES_WIDTH'(1);
                    cnt_nxt   = n;
                    state_nxt = ST_MULT;
                end
            end
            ST_MULT: begin
`ifdef FACT_ERR_EN
                if (cnt > N_WIDTH'(FACT_MAX_N)) begin
                    err_nxt    = 1'b1;
                    done_nxt   = 1'b1;
                    result_nxt = '0;
                    state_nxt  = ST_DONE;
                end else
`endif
                if (cnt <= N_WIDTH'(1)) begin
                    result_nxt = prod;
                    done_nxt   = 1'b1;
                    state_nxt  = ST_DONE;
                end else begin
                    prod_nxt = prod * RES_WIDTH'(cnt);
                    cnt_nxt  = cnt - N_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state == ST_MULT);
    assign done   = done_q;
    assign result = result_q;

`ifdef FACT_ERR_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: rtl/fact_mmio.sv
// -----------------------------------------------------------------------------
// fact_mmio
// Memory-mapped responder for the factorial accelerator slot. Decodes writes
// from the address decoder, owns the N operand register and the read-data mux,
// and drives the fact_fsm multiply engine.
// Register map (word offset a):
//   0 N      : RW, low FACT_N_WIDTH bits of wd, reads zero-extended
//   1 GO     : W wd[0]=1 starts a computation; reads {31'b0, busy}
//   2 STATUS : R {30'b0, err, done}
//   3 RESULT : R last completed result
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : fact_mmio_if slave (we, a, wd in; rd out)
// Macro: FACT_ERR_EN enables overflow detection inside fact_fsm.
// -----------------------------------------------------------------------------
module fact_mmio
    import fact_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    fact_mmio_if.slave  bus
);

    logic [FACT_N_WIDTH-1:0]   n_reg;
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      err;
    logic [FACT_RES_WIDTH-1:0] result;
    logic                      unused_wd;

    // N may be rewritten while the engine runs; the engine keeps its own
    // counter, so only the next computation sees the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg <= '0;
        end else if (bus.we && (bus.a == FACT_OFS_N)) begin
            n_reg <= bus.wd[FACT_N_WIDTH-1:0];
        end
    end

    // The engine itself ignores start while busy.
    assign start = bus.we && (bus.a == FACT_OFS_GO) && bus.wd[0];

    fact_fsm #(
        .N_WIDTH   (FACT_N_WIDTH),
        .RES_WIDTH (FACT_RES_WIDTH)
    ) u_fsm (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .n      (n_reg),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result)
    );

    always_comb begin
        bus.rd = '0;
        case (bus.a)
            FACT_OFS_N:      bus.rd = {{(32-FACT_N_WIDTH){1'b0}}, n_reg};
            FACT_OFS_GO:     bus.rd = {31'b0, busy};
            FACT_OFS_STATUS: bus.rd = {30'b0, err, done};
            FACT_OFS_RESULT: bus.rd = result;
            default:         bus.rd = '0;
        endcase
    end

    // Upper write-data bits have no register behind them.
    assign unused_wd = ^bus.wd[31:FACT_N_WIDTH];

endmodule

// File: tb/tb_fact_mmio.sv
// -----------------------------------------------------------------------------
// tb_fact_mmio
// Self-checking bench for fact_mmio: drives register writes through the
// fact_mmio_if bus, keeps expected completions in a queue, and compares
// STATUS/RESULT/latency when each computation finishes.
// Works with and without FACT_ERR_EN defined.
// -----------------------------------------------------------------------------
module tb_fact_mmio;
    import fact_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    fact_mmio_if bus();

    fact_mmio dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]  n;
        logic [31:0] exp_result;
        logic [31:0] exp_status;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [31:0] result;
        logic [31:0] status;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_result = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the write edge.
    task automatic applyStimulus(input logic [1:0] off, input logic [31:0] data);
        bus.we = 1'b1;
        bus.a  = off;
        bus.wd = data;
        @(posedge clk);
        @(negedge clk);
        bus.we = 1'b0;
        bus.wd = '0;
    endtask

    task automatic readReg(input logic [1:0] off, output logic [31:0] val);
        bus.a = off;
        #1;
        val = bus.rd;
    endtask

    // Writes N and GO (GO sampled at edge k), queues the expectation and checks
    // the state right after edge k.
    task automatic startOp(input logic [3:0] n, input exp_t e);
        logic [31:0] v;
        applyStimulus(FACT_OFS_N, {28'b0, n});
        applyStimulus(FACT_OFS_GO, 32'h1);
        sb.push_back(e);
        readReg(FACT_OFS_GO, v);
        checkOutput($sformatf("busy_after_go_n%0d", n), v, 32'h1);
        readReg(FACT_OFS_STATUS, v);
        checkOutput($sformatf("status_after_go_n%0d", n), v, 32'h0);
        readReg(FACT_OFS_RESULT, v);
        checkOutput($sformatf("result_held_n%0d", n), v, last_result);
    endtask

    // Counts edges after k until done is seen, bounded.
    task automatic waitDone(input int j0, output int j);
        logic [31:0] v;
        j = j0;
        readReg(FACT_OFS_STATUS, v);
        while (!v[0] && j < 40) begin
            @(negedge clk);
            j++;
            readReg(FACT_OFS_STATUS, v);
        end
        if (!v[0]) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout: got done=0 after %0d cycles expected done=1", j);
        end
    endtask

    task automatic finishOp(input string tag, input int exp_lat, input int j);
        exp_t        e;
        logic [31:0] v;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sb.pop_front();
            readReg(FACT_OFS_STATUS, v);
            checkOutput({tag, "_status"}, v, e.status);
            readReg(FACT_OFS_RESULT, v);
            checkOutput({tag, "_result"}, v, e.result);
            checkOutput({tag, "_latency"}, 32'(j), 32'(exp_lat));
            readReg(FACT_OFS_GO, v);
            checkOutput({tag, "_busy_clear"}, v, 32'h0);
            last_result = e.result;
        end
    endtask

    initial begin
        logic [31:0] v;
        int          j;

        bus.we = 1'b0;
        bus.a  = 2'd0;
        bus.wd = '0;

        vecs[0] = '{4'd5,  32'h0000_0078, 32'h1, 5};
        vecs[1] = '{4'd0,  32'h0000_0001, 32'h1, 1};
        vecs[2] = '{4'd1,  32'h0000_0001, 32'h1, 1};
        vecs[3] = '{4'd12, 32'h1C8C_FC00, 32'h1, 12};
`ifdef FACT_ERR_EN
        vecs[4] = '{4'd13, 32'h0000_0000, 32'h3, 1};
        vecs[6] = '{4'd15, 32'h0000_0000, 32'h3, 1};
`else
        vecs[4] = '{4'd13, 32'h7328_CC00, 32'h1, 13};
        vecs[6] = '{4'd15, 32'h7777_5800, 32'h1, 15};
`endif
        vecs[5] = '{4'd3,  32'h0000_0006, 32'h1, 3};
        vecs[7] = '{4'd2,  32'h0000_0002, 32'h1, 2};

        // Reset asserted mid-cycle, released on a falling edge.
        #3 rst_n = 1'b0;
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        for (int o = 0; o < 4; o++) begin
            readReg(2'(o), v);
            checkOutput($sformatf("reset_rd_ofs%0d", o), v, 32'h0);
        end

        // Table-driven computations.
        for (int i = 0; i < 8; i++) begin
            startOp(vecs[i].n, '{vecs[i].exp_result, vecs[i].exp_status});
            waitDone(0, j);
            finishOp($sformatf("vec%0d_n%0d", i, vecs[i].n), vecs[i].exp_lat, j);
            readReg(FACT_OFS_N, v);
            checkOutput($sformatf("vec%0d_n_readback", i), v, {28'b0, vecs[i].n});
        end

        // GO and N rewritten while busy: computation carries on with n=6.
        startOp(4'd6, '{32'h0000_02D0, 32'h1});
        applyStimulus(FACT_OFS_GO, 32'h1);
        applyStimulus(FACT_OFS_N, 32'h3);
        readReg(FACT_OFS_GO, v);
        checkOutput("busy_after_rewrite", v, 32'h1);
        waitDone(2, j);
        finishOp("rewrite_n6", 6, j);
        readReg(FACT_OFS_N, v);
        checkOutput("rewrite_n_reads_3", v, 32'h3);

        // Reset in the middle of a computation.
        startOp(4'd7, '{32'h0000_13B0, 32'h1});
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        last_result = '0;
        readReg(FACT_OFS_STATUS, v);
        checkOutput("midreset_status_async", v, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        readReg(FACT_OFS_STATUS, v);
        checkOutput("midreset_status", v, 32'h0);
        readReg(FACT_OFS_RESULT, v);
        checkOutput("midreset_result", v, 32'h0);
        readReg(FACT_OFS_GO, v);
        checkOutput("midreset_busy", v, 32'h0);
        readReg(FACT_OFS_N, v);
        checkOutput("midreset_n", v, 32'h0);
        startOp(4'd4, '{32'h0000_0018, 32'h1});
        waitDone(0, j);
        finishOp("after_reset_n4", 4, j);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
